// File: rtl/bram_arb_pkg.sv
// Shared types and constants for the BRAM arbiter: FSM states, owner IDs and
// the default Wishbone address window.
package bram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    ACK    = 2'd2
  } arb_state_t;

  localparam logic OWN_WB  = 1'b0;
  localparam logic OWN_USR = 1'b1;

  localparam logic [7:0] ADDR_BASE_DEF = 8'h38;
  localparam int         CNT_W         = 4;

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin grant: a tie goes to the port that was not served
// last. Grant is one-hot, bit 0 = Wishbone, bit 1 = user.
module rr_arb2
  import bram_arb_pkg::*;
(
  input  logic       i_wreq,
  input  logic       i_ureq,
  input  logic       i_last_owner,
  output logic [1:0] o_gnt
);

  always_comb begin
    o_gnt = 2'b00;
    if (i_wreq && i_ureq) begin
      o_gnt = (i_last_owner == OWN_USR) ? 2'b01 : 2'b10;
    end else if (i_wreq) begin
      o_gnt = 2'b01;
    end else if (i_ureq) begin
      o_gnt = 2'b10;
    end
  end

endmodule

// File: rtl/bram_arbiter.sv
// Shares a single-port BRAM between the Wishbone slave and one user port:
// round-robin grant, fixed DELAYS-cycle access window, one-cycle ack.
module bram_arbiter
  import bram_arb_pkg::*;
#(
  parameter int         DELAYS    = 10,
  parameter logic [7:0] ADDR_BASE = ADDR_BASE_DEF
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  input  logic        usr_req_i,
  input  logic [3:0]  usr_we_i,
  input  logic [31:0] usr_adr_i,
  input  logic [31:0] usr_dat_i,
  output logic        usr_gnt_o,
  output logic        usr_ack_o,
  output logic [31:0] usr_dat_o,
  output logic        bram_en_o,
  output logic [3:0]  bram_we_o,
  output logic [31:0] bram_adr_o,
  output logic [31:0] bram_di_o,
  input  logic [31:0] bram_do_i,
  output logic        busy_o
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DELAYS - 1);

  arb_state_t       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_owner;
  logic             r_last_owner;
  logic             r_wb_lost;
  logic [31:0]      r_adr;
  logic [31:0]      r_dat;
  logic [3:0]       r_we;
  logic [3:0]       r_bram_we;
  logic             r_bram_en;
  logic             r_usr_gnt;
  logic             r_wbs_ack;
  logic             r_usr_ack;
  logic [31:0]      r_wbs_dat;
  logic [31:0]      r_usr_dat;

  logic             w_wreq;
  logic             w_ureq;
  logic [1:0]       w_gnt;

  assign w_wreq = wbs_stb_i & wbs_cyc_i & (wbs_adr_i[31:24] == ADDR_BASE);
  assign w_ureq = usr_req_i;

  rr_arb2 u_rr_arb2 (
    .i_wreq       (w_wreq),
    .i_ureq       (w_ureq),
    .i_last_owner (r_last_owner),
    .o_gnt        (w_gnt)
  );

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_i) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_owner      <= OWN_WB;
      r_last_owner <= OWN_USR;
      r_wb_lost    <= 1'b0;
      r_adr        <= '0;
      r_dat        <= '0;
      r_we         <= '0;
      r_bram_we    <= '0;
      r_bram_en    <= 1'b0;
      r_usr_gnt    <= 1'b0;
      r_wbs_ack    <= 1'b0;
      r_usr_ack    <= 1'b0;
      r_wbs_dat    <= '0;
      r_usr_dat    <= '0;
    end else begin
      r_wbs_ack <= 1'b0;
      r_usr_ack <= 1'b0;
      r_bram_we <= '0;
      case (r_state)
        IDLE: begin
          if (|w_gnt) begin
            r_owner   <= w_gnt[1] ? OWN_USR : OWN_WB;
            r_usr_gnt <= w_gnt[1];
            r_bram_en <= 1'b1;
            r_cnt     <= '0;
            r_wb_lost <= 1'b0;
            r_state   <= ACCESS;
            if (w_gnt[0]) begin
              r_adr     <= wbs_adr_i;
              r_dat     <= wbs_dat_i;
              r_we      <= wbs_sel_i & {4{wbs_we_i}};
              r_bram_we <= wbs_sel_i & {4{wbs_we_i}};
            end else begin
              r_adr     <= usr_adr_i;
              r_dat     <= usr_dat_i;
              r_we      <= usr_we_i;
              r_bram_we <= usr_we_i;
            end
          end
        end
        ACCESS: begin
          r_cnt <= r_cnt + 1'b1;
          // A Wishbone master that abandons its cycle still gets its write
          // committed, but must not see an ack for it.
          if (r_owner == OWN_WB && !wbs_cyc_i) begin
            r_wb_lost <= 1'b1;
          end
          if (r_cnt == LAST_CNT) begin
            r_bram_en <= 1'b0;
            r_state   <= ACK;
            if (r_owner == OWN_WB) begin
              r_wbs_ack <= ~r_wb_lost & wbs_cyc_i;
              if (r_we == 4'b0000) r_wbs_dat <= bram_do_i;
            end else begin
              r_usr_ack <= 1'b1;
              if (r_we == 4'b0000) r_usr_dat <= bram_do_i;
            end
          end
        end
        ACK: begin
          r_last_owner <= r_owner;
          r_usr_gnt    <= 1'b0;
          r_state      <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign wbs_ack_o  = r_wbs_ack;
  assign wbs_dat_o  = r_wbs_dat;
  assign usr_gnt_o  = r_usr_gnt;
  assign usr_ack_o  = r_usr_ack;
  assign usr_dat_o  = r_usr_dat;
  assign bram_en_o  = r_bram_en;
  assign bram_we_o  = r_bram_we;
  assign bram_adr_o = r_adr;
  assign bram_di_o  = r_dat;
  assign busy_o     = (r_state != IDLE);

endmodule

// File: tb/tb_bram_arbiter.sv
// Scoreboard bench for bram_arbiter with a behavioural 1-cycle BRAM model.
module tb_bram_arbiter;

  localparam int DLY = 10;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wbs_stb, wbs_cyc, wbs_we;
  logic [3:0]  wbs_sel;
  logic [31:0] wbs_adr, wbs_dat;
  logic        wbs_ack;
  logic [31:0] wbs_rdat;
  logic        usr_req;
  logic [3:0]  usr_we;
  logic [31:0] usr_adr, usr_dat;
  logic        usr_gnt, usr_ack;
  logic [31:0] usr_rdat;
  logic        bram_en;
  logic [3:0]  bram_we;
  logic [31:0] bram_adr, bram_di, bram_do;
  logic        busy;

  logic [31:0] mem [0:255];
  int cyc = 0;
  int n_tests = 0;
  int n_fail = 0;

  typedef struct {
    logic [31:0] dat;
    int          cyc;
    bit          chk;
  } exp_t;

  exp_t wq[$];
  exp_t uq[$];
  exp_t mon_w, mon_u;

  bram_arbiter #(.DELAYS(DLY), .ADDR_BASE(8'h38)) dut (
    .wb_clk_i  (clk),
    .wb_rst_i  (rst_n),
    .wbs_stb_i (wbs_stb),
    .wbs_cyc_i (wbs_cyc),
    .wbs_we_i  (wbs_we),
    .wbs_sel_i (wbs_sel),
    .wbs_adr_i (wbs_adr),
    .wbs_dat_i (wbs_dat),
    .wbs_ack_o (wbs_ack),
    .wbs_dat_o (wbs_rdat),
    .usr_req_i (usr_req),
    .usr_we_i  (usr_we),
    .usr_adr_i (usr_adr),
    .usr_dat_i (usr_dat),
    .usr_gnt_o (usr_gnt),
    .usr_ack_o (usr_ack),
    .usr_dat_o (usr_rdat),
    .bram_en_o (bram_en),
    .bram_we_o (bram_we),
    .bram_adr_o(bram_adr),
    .bram_di_o (bram_di),
    .bram_do_i (bram_do),
    .busy_o    (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Read-first BRAM with per-byte write enables and registered output
  always @(posedge clk) begin
    if (bram_en) begin
      for (int b = 0; b < 4; b++)
        if (bram_we[b]) mem[bram_adr[9:2]][b*8 +: 8] <= bram_di[b*8 +: 8];
      bram_do <= mem[bram_adr[9:2]];
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic fail_now(input string nm);
    n_tests++;
    n_fail++;
    $display("FAIL %s: got no response expected a response", nm);
  endtask

  // Monitor: every ack must match the oldest pending expectation
  always @(negedge clk) begin
    if (wbs_ack) begin
      if (wq.size() == 0) begin
        fail_now("wb_ack_unexpected");
      end else begin
        mon_w = wq.pop_front();
        chk("wb_ack_cycle", 32'(cyc), 32'(mon_w.cyc));
        if (mon_w.chk) chk("wb_rdata", wbs_rdat, mon_w.dat);
        chk("usr_gnt_during_wb", {31'b0, usr_gnt}, 32'd0);
      end
    end
    if (usr_ack) begin
      if (uq.size() == 0) begin
        fail_now("usr_ack_unexpected");
      end else begin
        mon_u = uq.pop_front();
        chk("usr_ack_cycle", 32'(cyc), 32'(mon_u.cyc));
        if (mon_u.chk) chk("usr_rdata", usr_rdat, mon_u.dat);
        chk("usr_gnt_during_usr", {31'b0, usr_gnt}, 32'd1);
      end
    end
  end

  task automatic wb_xfer(input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel,
                         input logic we, input logic [31:0] exp, input int lat);
    exp_t e;
    bit got;
    @(negedge clk);
    e.dat = exp; e.cyc = cyc + lat; e.chk = !we;
    wq.push_back(e);
    wbs_adr = adr; wbs_dat = dat; wbs_sel = sel; wbs_we = we;
    wbs_stb = 1'b1; wbs_cyc = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      if (wbs_ack) got = 1'b1;
    end
    if (!got) fail_now("wb_ack_timeout");
    wbs_stb = 1'b0; wbs_cyc = 1'b0; wbs_we = 1'b0;
  endtask

  task automatic usr_xfer(input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] we,
                          input logic [31:0] exp, input int lat);
    exp_t e;
    bit got;
    @(negedge clk);
    e.dat = exp; e.cyc = cyc + lat; e.chk = (we == 4'b0000);
    uq.push_back(e);
    usr_adr = adr; usr_dat = dat; usr_we = we; usr_req = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      if (usr_ack) got = 1'b1;
    end
    if (!got) fail_now("usr_ack_timeout");
    usr_req = 1'b0; usr_we = 4'b0000;
  endtask

  task automatic wait_busy(input logic lvl, input string nm);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      if (busy == lvl) ok = 1'b1;
    end
    if (!ok) fail_now(nm);
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_busy"},    {31'b0, busy},    32'd0);
    chk({tag, "_wbs_ack"}, {31'b0, wbs_ack}, 32'd0);
    chk({tag, "_wbs_dat"}, wbs_rdat,         32'd0);
    chk({tag, "_usr_gnt"}, {31'b0, usr_gnt}, 32'd0);
    chk({tag, "_usr_ack"}, {31'b0, usr_ack}, 32'd0);
    chk({tag, "_usr_dat"}, usr_rdat,         32'd0);
    chk({tag, "_bram_en"}, {31'b0, bram_en}, 32'd0);
    chk({tag, "_bram_we"}, {28'b0, bram_we}, 32'd0);
    chk({tag, "_bram_adr"}, bram_adr,        32'd0);
    chk({tag, "_bram_di"}, bram_di,          32'd0);
  endtask

  initial begin
    bit busy_seen;
    rst_n = 1'b0;
    wbs_stb = 0; wbs_cyc = 0; wbs_we = 0; wbs_sel = 0; wbs_adr = 0; wbs_dat = 0;
    usr_req = 0; usr_we = 0; usr_adr = 0; usr_dat = 0;
    repeat (3) @(negedge clk);
    chk_outputs_zero("reset");
    rst_n = 1'b1;

    // Simultaneous requests: Wishbone wins after reset, user follows
    fork
      wb_xfer(32'h3800_0040, 32'h1234_5678, 4'hF, 1'b1, 32'h0, DLY + 1);
      usr_xfer(32'h0000_0040, 32'h0, 4'b0000, 32'h1234_5678, 2 * DLY + 3);
    join

    // Wishbone write then read
    wb_xfer(32'h3800_0010, 32'hDEAD_BEEF, 4'hF, 1'b1, 32'h0, DLY + 1);
    wb_xfer(32'h3800_0010, 32'h0, 4'hF, 1'b0, 32'hDEAD_BEEF, DLY + 1);

    // Byte-lane write
    wb_xfer(32'h3800_0020, 32'hAAAA_AAAA, 4'hF, 1'b1, 32'h0, DLY + 1);
    wb_xfer(32'h3800_0020, 32'h1122_3344, 4'b0101, 1'b1, 32'h0, DLY + 1);
    wb_xfer(32'h3800_0020, 32'h0, 4'hF, 1'b0, 32'hAA22_AA44, DLY + 1);

    // User port writes, partial byte write, read back
    usr_xfer(32'h0000_0080, 32'h5A5A_0001, 4'hF, 32'h0, DLY + 1);
    usr_xfer(32'h0000_00C0, 32'h0123_4567, 4'hF, 32'h0, DLY + 1);
    usr_xfer(32'h0000_00C0, 32'hFF00_0000, 4'b1000, 32'h0, DLY + 1);
    usr_xfer(32'h0000_00C0, 32'h0, 4'b0000, 32'hFF23_4567, DLY + 1);

    // Address miss: never busy, never acked
    @(negedge clk);
    wbs_adr = 32'h3000_0000; wbs_we = 1'b0; wbs_sel = 4'hF;
    wbs_stb = 1'b1; wbs_cyc = 1'b1;
    busy_seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (busy) busy_seen = 1'b1;
    end
    chk("miss_busy", {31'b0, busy_seen}, 32'd0);
    wbs_stb = 1'b0; wbs_cyc = 1'b0;

    // Wishbone write abandoned mid-access behind a user read
    fork
      usr_xfer(32'h0000_0080, 32'h0, 4'b0000, 32'h5A5A_0001, DLY + 1);
      begin
        @(negedge clk);
        @(negedge clk);
        wbs_adr = 32'h3800_0084; wbs_dat = 32'h0BAD_CAFE; wbs_sel = 4'hF;
        wbs_we = 1'b1; wbs_stb = 1'b1; wbs_cyc = 1'b1;
      end
    join
    wait_busy(1'b0, "abort_idle_timeout");
    wait_busy(1'b1, "abort_grant_timeout");
    repeat (2) @(negedge clk);
    wbs_stb = 1'b0; wbs_cyc = 1'b0; wbs_we = 1'b0;
    wait_busy(1'b0, "abort_done_timeout");
    repeat (3) @(negedge clk);
    wb_xfer(32'h3800_0084, 32'h0, 4'hF, 1'b0, 32'h0BAD_CAFE, DLY + 1);
    chk("usr_dat_hold", usr_rdat, 32'h5A5A_0001);

    // Reset in the fifth access cycle
    @(negedge clk);
    wbs_adr = 32'h3800_0010; wbs_we = 1'b0; wbs_sel = 4'hF;
    wbs_stb = 1'b1; wbs_cyc = 1'b1;
    wait_busy(1'b1, "rst_grant_timeout");
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    wbs_stb = 1'b0; wbs_cyc = 1'b0;
    @(negedge clk);
    chk_outputs_zero("midrst");
    rst_n = 1'b1;
    wb_xfer(32'h3800_0010, 32'h0, 4'hF, 1'b0, 32'hDEAD_BEEF, DLY + 1);

    repeat (20) @(negedge clk);
    chk("wb_queue_drained", 32'(wq.size()), 32'd0);
    chk("usr_queue_drained", 32'(uq.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got hang expected completion");
    $fatal(1, "timeout");
  end

endmodule
